// File: rtl/a2d_spi_mstr_if.sv
// Signal bundle between slide_intf and the ADC SPI master: conversion handshake plus the SPI pins.
// strt_cnv is a one-cycle request honoured only while the master is idle; res is valid while cnv_cmplt is high.
interface a2d_spi_mstr_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        a2d_SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  strt_cnv,
        input  chnnl,
        input  MISO,
        output cnv_cmplt,
        output res,
        output a2d_SS_n,
        output SCLK,
        output MOSI
    );

    modport slave (
        output strt_cnv,
        output chnnl,
        output MISO,
        input  cnv_cmplt,
        input  res,
        input  a2d_SS_n,
        input  SCLK,
        input  MOSI
    );
endinterface

// File: rtl/a2d_spi_mstr.sv
// SPI master for the 8-channel pot ADC: two 16-bit frames per conversion, the second frame
// returns the 12-bit result of the channel addressed in both frames.
module a2d_spi_mstr #(
    parameter int GAP_CLKS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    a2d_spi_mstr_if.master   bus,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRAME1 = 2'd1,
        GAP    = 2'd2,
        FRAME2 = 2'd3
    } state_t;

    localparam logic [4:0] SCLK_LOAD = 5'b10010;
    localparam logic [4:0] SHIFT_PT  = 5'b10000;
    localparam logic [4:0] GAP_LAST  = 5'(GAP_CLKS - 1);
    localparam logic [4:0] LAST_BIT  = 5'd16;

    state_t      state_q, state_d;
    logic        ss_n_q, ss_n_d;
    logic [4:0]  sclk_cnt_q, sclk_cnt_d;
    logic [4:0]  shft_cnt_q, shft_cnt_d;
    logic [4:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [2:0]  chnnl_q, chnnl_d;
    logic [11:0] res_q, res_d;
    logic        cmplt_q, cmplt_d;
    logic [15:0] cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ss_n_q     <= 1'b1;
            sclk_cnt_q <= SCLK_LOAD;
            shft_cnt_q <= 5'd0;
            gap_cnt_q  <= 5'd0;
            shreg_q    <= 16'h0000;
            chnnl_q    <= 3'd0;
            res_q      <= 12'h000;
            cmplt_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ss_n_q     <= ss_n_d;
            sclk_cnt_q <= sclk_cnt_d;
            shft_cnt_q <= shft_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            shreg_q    <= shreg_d;
            chnnl_q    <= chnnl_d;
            res_q      <= res_d;
            cmplt_q    <= cmplt_d;
        end
    end

    assign cmd = {2'b00, chnnl_q, 11'h000};

    always_comb begin
        state_d    = state_q;
        ss_n_d     = ss_n_q;
        sclk_cnt_d = SCLK_LOAD;
        shft_cnt_d = shft_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        shreg_d    = shreg_q;
        chnnl_d    = chnnl_q;
        res_d      = res_q;
        cmplt_d    = cmplt_q;

        case (state_q)
            IDLE: begin
                if (bus.strt_cnv) begin
                    chnnl_d = bus.chnnl;
                    state_d = FRAME1;
                end
            end

            FRAME1, FRAME2: begin
                // First cycle after acceptance: chip select drops and the frame is armed.
                if (ss_n_q) begin
                    ss_n_d     = 1'b0;
                    shreg_d    = cmd;
                    shft_cnt_d = 5'd0;
                    cmplt_d    = 1'b0;
                end else if (shft_cnt_q == LAST_BIT) begin
                    ss_n_d = 1'b1;
                    if (state_q == FRAME1) begin
                        state_d   = GAP;
                        gap_cnt_d = 5'd0;
                    end else begin
                        state_d = IDLE;
                        res_d   = shreg_q[11:0];
                        cmplt_d = 1'b1;
                    end
                end else begin
                    sclk_cnt_d = sclk_cnt_q + 5'd1;
                    // Sample MISO on the edge right after SCLK rises; MOSI moves here too.
                    if (sclk_cnt_q == SHIFT_PT) begin
                        shreg_d    = {shreg_q[14:0], bus.MISO};
                        shft_cnt_d = shft_cnt_q + 5'd1;
                    end
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d    = FRAME2;
                    ss_n_d     = 1'b0;
                    shreg_d    = cmd;
                    shft_cnt_d = 5'd0;
                    gap_cnt_d  = 5'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 5'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.a2d_SS_n  = ss_n_q;
    assign bus.SCLK      = sclk_cnt_q[4];
    assign bus.MOSI      = shreg_q[15];
    assign bus.res       = res_q;
    assign bus.cnv_cmplt = cmplt_q;
    assign state_o       = state_q;

endmodule
